// File: rtl/seg_decode.sv
// Seven-segment bus decoder: synchronizes an active-low segment/enable bus,
// debounces the pattern over STABLE_CYCLES samples and reports the hex digit.
module seg_decode #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  input  logic       en_in,
  output logic [3:0] value,
  output logic       dp,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       locked
);

  localparam int unsigned SEG_W = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned VAL_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q;
  logic [SEG_W-1:0]   seg_s1_q, seg_s2_q;
  logic               en_s1_q, en_s2_q;
  logic [SEG_W-1:0]   cand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VAL_W-1:0]   value_q;
  logic               dp_q;
  logic               valid_q;
  logic               err_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic               locked_q;
  logic               legal_c;
  logic [VAL_W-1:0]   digit_c;
  logic               differ_c;

  // Two-flop synchronizers; reset to the idle (all-off, disabled) bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      en_s1_q  <= 1'b1;
      en_s2_q  <= 1'b1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      en_s1_q  <= en_in;
      en_s2_q  <= en_s1_q;
    end
  end

  // Segment decode of the candidate; the decimal point is not part of the match.
  always_comb begin
    legal_c = 1'b1;
    digit_c = '0;
    case (cand_q[6:0])
      7'h40: digit_c = 4'h0;
      7'h79: digit_c = 4'h1;
      7'h24: digit_c = 4'h2;
      7'h30: digit_c = 4'h3;
      7'h19: digit_c = 4'h4;
      7'h12: digit_c = 4'h5;
      7'h02: digit_c = 4'h6;
      7'h78: digit_c = 4'h7;
      7'h00: digit_c = 4'h8;
      7'h10: digit_c = 4'h9;
      7'h08: digit_c = 4'hA;
      7'h03: digit_c = 4'hB;
      7'h46: digit_c = 4'hC;
      7'h21: digit_c = 4'hD;
      7'h06: digit_c = 4'hE;
      7'h0E: digit_c = 4'hF;
      default: legal_c = 1'b0;
    endcase
  end

  assign differ_c = (seg_s2_q != cand_q);

  // Debounce FSM with registered pulses and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cand_q    <= '1;
      cnt_q     <= '0;
      value_q   <= '0;
      dp_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (en_s2_q) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cand_q  <= seg_s2_q;
            cnt_q   <= CNT_W'(1);
            state_q <= SETTLE;
          end
          SETTLE: begin
            if (differ_c) begin
              cand_q <= seg_s2_q;
              cnt_q  <= CNT_W'(1);
            end else if (cnt_q >= CNT_LAST) begin
              cnt_q    <= CNT_FULL;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              if (legal_c) begin
                valid_q <= 1'b1;
                value_q <= digit_c;
                dp_q    <= ~cand_q[7];
              end else begin
                err_q <= 1'b1;
                if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          LOCKED: begin
            if (differ_c) begin
              cand_q   <= seg_s2_q;
              cnt_q    <= CNT_W'(1);
              state_q  <= SETTLE;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign value   = value_q;
  assign dp      = dp_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign locked  = locked_q;

endmodule

// File: doc/seg_decode.md
SEG_DECODE -- requirements
Module: seg_decode

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, is the number of consecutive identical synchronized samples required before a pattern is accepted; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 seg_in  input  8  active-low segment bus; bit7 = dp, bits6:0 = segments g..a.
REQ-005 en_in  input  1  active-low digit enable; the pattern is meaningful only while en_in = 0.
REQ-006 value  output  4  last accepted hex digit.
REQ-007 dp  output  1  decimal point of the last accepted pattern, active-high (inverse of seg_in[7]).
REQ-008 valid  output  1  one-cycle pulse: a legal pattern was accepted.
REQ-009 err  output  1  one-cycle pulse: a stable but illegal pattern was accepted.
REQ-010 err_cnt  output  8  count of err pulses, saturating at 255.
REQ-011 locked  output  1  high while in state LOCKED.

Function
REQ-012 seg_in and en_in shall each pass through a two-flop synchronizer before any other use.
REQ-013 The legal table on bits6:0 shall be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex); all other codes are illegal. bit7 is not part of the match.
REQ-014 States: IDLE, SETTLE, LOCKED; reset state is IDLE.
REQ-015 IDLE: if the synced en_in is 0, load the synced pattern into the candidate register, clear the counter to 1, go to SETTLE.
REQ-016 SETTLE: if the synced pattern equals the candidate, increment the counter; if it differs, reload the candidate, set the counter to 1, stay in SETTLE.
REQ-017 SETTLE: when the counter would reach STABLE_CYCLES with a matching sample, accept the candidate, pulse valid or err for exactly one cycle, and go to LOCKED.
REQ-018 On valid: update value and dp in the same cycle valid is high. On err: leave value and dp unchanged and increment err_cnt unless it is 255.
REQ-019 LOCKED: if the synced pattern differs from the candidate, reload the candidate, set the counter to 1, and go to SETTLE; otherwise stay, with no further pulses.
REQ-020 In any state, a synced en_in of 1 forces IDLE on the next edge and discards any partial count. It has priority over every other transition.
REQ-021 Latency: for a seg_in held constant with en_in = 0 from edge k, valid or err shall be high during the cycle after edge k+STABLE_CYCLES+2. This holds when the previous state was IDLE, or LOCKED with a different pattern.
REQ-022 Two legal patterns differing only in bit7 are different patterns and require a fresh settle.
REQ-023 valid and err shall never be high in the same cycle.
REQ-024 The counter shall not wrap. It is held once it reaches STABLE_CYCLES.

Reset
REQ-025 While rst_n = 0: state = IDLE, value = 0, dp = 0, valid = 0, err = 0, err_cnt = 0, locked = 0, synchronizers = 8'hFF / 1'b1.
REQ-026 Reset assertion mid-SETTLE or mid-LOCKED takes effect immediately with no pulse emitted. After release, operation restarts from IDLE.

Verification (STABLE_CYCLES = 4)
REQ-027 Hold seg_in = 8'hA4 with en_in = 0 -> single valid pulse 6 edges later; value = 2, dp = 0, locked = 1; no further pulses over 50 cycles.
REQ-028 Drive 8'h99, then toggle to 8'h92 after 3 cycles and hold -> no pulse for 8'h99; valid with value = 5 exactly 6 edges after 8'h92 is applied.
REQ-029 Hold 8'hFF (blank), then 8'h7F -> err pulse for each, err_cnt = 2, value keeps its prior value; force 256 illegal settles -> err_cnt stays 255.
REQ-030 Accept 8'hC0 (value 0), then apply 8'h40 -> fresh settle, valid with value = 0 and dp = 1.
REQ-031 Raise en_in mid-SETTLE, lower it 2 cycles later with the same pattern -> no pulse until a full 4-sample settle completes after re-entry.
REQ-032 Assert rst_n = 0 one cycle before an expected valid -> no pulse, all outputs reach their reset values asynchronously, and a normal settle occurs after release.
